branch_predict_unit: RTL and testbench

Parametrised successor to the combinational branch-target adder. It computes branch and jump targets exactly as before, and adds a direct-mapped branch target buffer (BTB) with a 2-bit bimodal counter per entry. Fetch gets a same-cycle taken/target prediction. EX resolves each control instruction, updates the table, raises mispredict/redirect, and keeps saturating performance counters.

---
 rtl/branch_predict_unit_pkg.sv | 27 ++
 rtl/branch_predict_unit_bimodal_counter.sv | 29 ++
 rtl/branch_predict_unit.sv | 165 ++++++++++++++++
 tb/tb_branch_predict_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit.
// Holds the 2-bit bimodal counter encodings, the sequential PC step and a
// clog2 helper used to size the BTB index from the entry count.
package branch_predict_unit_pkg;

    // 2-bit bimodal counter states; bit 1 is the taken/not-taken prediction
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Distance from one instruction to the next
    localparam int PC_INCREASE = 4;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_predict_unit_bimodal_counter.sv
// Next-state logic of a 2-bit saturating bimodal counter.
// Ports:
//   ctr      - current counter value
//   taken    - resolved branch direction
//   ctr_next - counter after counting up (taken) or down (not taken),
//              saturating at strongly taken / strongly not-taken
module bimodal_counter
    import branch_predict_unit_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Walk one step toward the resolved direction, holding at either end
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                ctr_next = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                ctr_next = ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: branch/jump target adder plus a direct-mapped BTB
// with a 2-bit bimodal counter per entry.
// Ports:
//   clk, arst                  - clock, asynchronous active-high reset
//   fetch_pc -> pred_taken, pred_pc   same-cycle fetch prediction
//   ex_* , updated_pc, immediate_extended
//                              - the resolving instruction in EX
//   btb_clear                  - synchronous invalidate of every entry
//   branch_pc, jump_pc         - updated_pc + immediate_extended
//   mispredict, redirect_pc    - fetch redirect for the EX instruction
//   ctrl_count, mispredict_count - saturating performance counters
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [DATA_W-1:0] fetch_pc,
    output logic              pred_taken,
    output logic [DATA_W-1:0] pred_pc,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic              ex_is_jump,
    input  logic              ex_taken,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [DATA_W-1:0] updated_pc,
    input  logic [DATA_W-1:0] immediate_extended,
    input  logic              ex_pred_taken,
    input  logic [DATA_W-1:0] ex_pred_pc,
    input  logic              btb_clear,
    output logic [DATA_W-1:0] branch_pc,
    output logic [DATA_W-1:0] jump_pc,
    output logic              mispredict,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  ctrl_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int IDX_W = clog2(BTB_ENTRIES);
    localparam int TAG_W = DATA_W - IDX_W - 2;

    logic              valid_q  [BTB_ENTRIES];
    logic              valid_d  [BTB_ENTRIES];
    logic [TAG_W-1:0]  tag_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]  tag_d    [BTB_ENTRIES];
    logic [DATA_W-1:0] target_q [BTB_ENTRIES];
    logic [DATA_W-1:0] target_d [BTB_ENTRIES];
    logic [1:0]        ctr_q    [BTB_ENTRIES];
    logic [1:0]        ctr_d    [BTB_ENTRIES];

    logic [CNT_W-1:0]  ctrl_count_q, ctrl_count_d;
    logic [CNT_W-1:0]  mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0]  fetch_idx, ex_idx;
    logic [TAG_W-1:0]  fetch_tag, ex_tag;
    logic              fetch_hit, ex_hit;
    logic              active, actual_taken;
    logic [DATA_W-1:0] target_sum;
    logic [1:0]        ctr_next;

    // The two byte-offset bits never address the table
    logic              unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], ex_pc[1:0]};

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign fetch_tag = fetch_pc[DATA_W-1:IDX_W+2];
    assign ex_idx    = ex_pc[IDX_W+1:2];
    assign ex_tag    = ex_pc[DATA_W-1:IDX_W+2];

    // Fetch-side lookup reads the registered table, so a write in this
    // cycle is only seen from the next one
    assign fetch_hit  = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign pred_taken = fetch_hit && ctr_q[fetch_idx][1];
    assign pred_pc    = pred_taken ? target_q[fetch_idx]
                                   : fetch_pc + DATA_W'(PC_INCREASE);

    // Branches and jumps share one target adder
    assign target_sum   = updated_pc + immediate_extended;
    assign branch_pc    = target_sum;
    assign jump_pc      = target_sum;

    assign active       = ex_valid && (ex_is_branch || ex_is_jump);
    assign actual_taken = ex_is_jump || ex_taken;
    assign ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // A wrong target counts as a mispredict only when the branch is taken
    assign mispredict  = active && ((ex_pred_taken != actual_taken) ||
                                    (actual_taken && (ex_pred_pc != target_sum)));
    assign redirect_pc = (active && actual_taken) ? target_sum : updated_pc;

    bimodal_counter u_bimodal_counter (
        .ctr      (ctr_q[ex_idx]),
        .taken    (actual_taken),
        .ctr_next (ctr_next)
    );

    // Table update; clear overrides any update or allocation in the same cycle
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (btb_clear) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (active) begin
            if (ex_hit) begin
                if (ex_is_jump) begin
                    ctr_d[ex_idx]    = CTR_ST;
                    target_d[ex_idx] = target_sum;
                end else begin
                    ctr_d[ex_idx] = ctr_next;
                    if (actual_taken) begin
                        target_d[ex_idx] = target_sum;
                    end
                end
            end else if (actual_taken) begin
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = target_sum;
                ctr_d[ex_idx]    = ex_is_jump ? CTR_ST : CTR_WT;
            end
        end
    end

    // Performance counters stick at all-ones instead of wrapping
    always_comb begin
        ctrl_count_d       = ctrl_count_q;
        mispredict_count_d = mispredict_count_q;
        if (active && (ctrl_count_q != {CNT_W{1'b1}})) begin
            ctrl_count_d = ctrl_count_q + CNT_W'(1);
        end
        if (mispredict && (mispredict_count_q != {CNT_W{1'b1}})) begin
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
            ctrl_count_q       <= '0;
            mispredict_count_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            ctrl_count_q       <= ctrl_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign ctrl_count       = ctrl_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed by
// randomized traffic, compared against an entry-level behavioural model.
// A second instance with 4-bit counters shares all inputs to show saturation.
module tb_branch_predict_unit;

    logic        clk;
    logic        arst;
    logic [15:0] fetch_pc;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken;
    logic [15:0] ex_pc, updated_pc, immediate_extended, ex_pred_pc;
    logic        ex_pred_taken, btb_clear;

    logic        pred_taken, mispredict;
    logic [15:0] pred_pc, branch_pc, jump_pc, redirect_pc;
    logic [31:0] ctrl_count, mispredict_count;

    logic        s4PredTaken, s4Mispredict;
    logic [15:0] s4PredPc, s4BranchPc, s4JumpPc, s4RedirectPc;
    logic [3:0]  s4CtrlCount, s4MispredictCount;

    int testsRun;
    int testsFailed;

    // Behavioural model: one record per table slot
    bit mValid  [16];
    int mTag    [16];
    int mTarget [16];
    int mCtr    [16];
    int mCtrl;
    int mMisp;

    // DUT values seen during the most recent applyStimulus
    int obsMis, obsRed, obsBpc, obsJpc;

    branch_predict_unit #(.DATA_W(16), .BTB_ENTRIES(16), .CNT_W(32)) dut (
        .clk(clk), .arst(arst), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_pc(pred_pc),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_taken(ex_taken), .ex_pc(ex_pc), .updated_pc(updated_pc),
        .immediate_extended(immediate_extended), .ex_pred_taken(ex_pred_taken),
        .ex_pred_pc(ex_pred_pc), .btb_clear(btb_clear),
        .branch_pc(branch_pc), .jump_pc(jump_pc), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .ctrl_count(ctrl_count),
        .mispredict_count(mispredict_count)
    );

    branch_predict_unit #(.DATA_W(16), .BTB_ENTRIES(16), .CNT_W(4)) dutSat (
        .clk(clk), .arst(arst), .fetch_pc(fetch_pc),
        .pred_taken(s4PredTaken), .pred_pc(s4PredPc),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_taken(ex_taken), .ex_pc(ex_pc), .updated_pc(updated_pc),
        .immediate_extended(immediate_extended), .ex_pred_taken(ex_pred_taken),
        .ex_pred_pc(ex_pred_pc), .btb_clear(btb_clear),
        .branch_pc(s4BranchPc), .jump_pc(s4JumpPc), .mispredict(s4Mispredict),
        .redirect_pc(s4RedirectPc), .ctrl_count(s4CtrlCount),
        .mispredict_count(s4MispredictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int idxOf(input int pc);
        return (pc / 4) % 16;
    endfunction

    function automatic int tagOf(input int pc);
        return pc / 64;
    endfunction

    function automatic bit modelTaken(input int pc);
        int i;
        i = idxOf(pc);
        return mValid[i] && (mTag[i] == tagOf(pc)) && (mCtr[i] >= 2);
    endfunction

    function automatic int modelTarget(input int pc);
        if (modelTaken(pc)) return mTarget[idxOf(pc)];
        return (pc + 4) % 65536;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 16; i++) begin
            mValid[i]  = 1'b0;
            mTag[i]    = 0;
            mTarget[i] = 0;
            mCtr[i]    = 1;
        end
        mCtrl = 0;
        mMisp = 0;
    endfunction

    // Park EX and look up one fetch address without clocking
    task automatic idleFetch(input int fpc);
        ex_valid = 1'b0;
        btb_clear = 1'b0;
        fetch_pc = 16'(fpc);
        #2;
        checkOutput("idle_pred_taken", 32'(pred_taken), 32'(modelTaken(fpc)));
        checkOutput("idle_pred_pc", 32'(pred_pc), 32'(modelTarget(fpc)));
    endtask

    // Drive one cycle, check combinational outputs, clock, then check counters
    task automatic applyStimulus(input bit valid, input bit br, input bit jmp,
                                 input bit tk, input int pc, input int imm,
                                 input bit pt, input int ppc, input bit clr,
                                 input int fpc);
        int upc, bpc, apc, red, j;
        bit act, at, mis, hit;
        upc = (pc + 4) % 65536;
        bpc = (upc + imm) % 65536;
        act = valid && (br || jmp);
        at  = jmp || tk;
        apc = at ? bpc : upc;
        red = act ? apc : upc;
        mis = act && ((pt != at) || (at && (ppc != bpc)));

        ex_valid = valid; ex_is_branch = br; ex_is_jump = jmp; ex_taken = tk;
        ex_pc = 16'(pc); updated_pc = 16'(upc); immediate_extended = 16'(imm);
        ex_pred_taken = pt; ex_pred_pc = 16'(ppc); btb_clear = clr;
        fetch_pc = 16'(fpc);
        #2;
        checkOutput("pred_taken", 32'(pred_taken), 32'(modelTaken(fpc)));
        checkOutput("pred_pc", 32'(pred_pc), 32'(modelTarget(fpc)));
        checkOutput("branch_pc", 32'(branch_pc), 32'(bpc));
        checkOutput("jump_pc", 32'(jump_pc), 32'(bpc));
        checkOutput("mispredict", 32'(mispredict), 32'(mis));
        checkOutput("redirect_pc", 32'(redirect_pc), 32'(red));
        obsMis = int'(mispredict); obsRed = int'(redirect_pc);
        obsBpc = int'(branch_pc);  obsJpc = int'(jump_pc);

        @(posedge clk);
        if (clr) begin
            for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
        end else if (act) begin
            j = idxOf(pc);
            hit = mValid[j] && (mTag[j] == tagOf(pc));
            if (hit) begin
                if (jmp) begin
                    mCtr[j] = 3;
                    mTarget[j] = bpc;
                end else begin
                    mCtr[j] = at ? ((mCtr[j] < 3) ? mCtr[j] + 1 : 3)
                                 : ((mCtr[j] > 0) ? mCtr[j] - 1 : 0);
                    if (at) mTarget[j] = bpc;
                end
            end else if (at) begin
                mValid[j] = 1'b1;
                mTag[j] = tagOf(pc);
                mTarget[j] = bpc;
                mCtr[j] = jmp ? 3 : 2;
            end
        end
        if (act) mCtrl++;
        if (mis) mMisp++;
        #1;
        checkOutput("ctrl_count", ctrl_count, 32'(mCtrl));
        checkOutput("mispredict_count", mispredict_count, 32'(mMisp));
        checkOutput("sat_ctrl_count", 32'(s4CtrlCount), 32'((mCtrl > 15) ? 15 : mCtrl));
        checkOutput("sat_mispredict_count", 32'(s4MispredictCount),
                    32'((mMisp > 15) ? 15 : mMisp));
    endtask

    task automatic randomStep();
        int pc, fpc, imm, ppc;
        bit pt, valid, br, jmp, clr;
        pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
        fpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
        imm = $urandom_range(0, 65535);
        valid = ($urandom_range(0, 9) < 8);
        br  = $urandom_range(0, 1);
        jmp = ($urandom_range(0, 3) == 0);
        clr = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 9) < 7) begin
            pt  = modelTaken(pc);
            ppc = modelTarget(pc);
        end else begin
            pt  = $urandom_range(0, 1);
            ppc = $urandom_range(0, 65535);
        end
        applyStimulus(valid, br, jmp, $urandom_range(0, 1), pc, imm, pt, ppc, clr, fpc);
    endtask

    task automatic doReset();
        arst = 1'b1;
        ex_valid = 1'b0;
        btb_clear = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0;
        ex_pc = '0; updated_pc = '0; immediate_extended = '0;
        ex_pred_taken = 1'b0; ex_pred_pc = '0; fetch_pc = '0;
        doReset();

        // Reset state
        idleFetch(16'h0040);
        checkOutput("rst_pred_taken", 32'(pred_taken), 0);
        checkOutput("rst_pred_pc", 32'(pred_pc), 32'h0044);
        checkOutput("rst_ctrl_count", ctrl_count, 0);
        checkOutput("rst_mispredict_count", mispredict_count, 0);

        // Allocate on a taken branch
        applyStimulus(1, 1, 0, 1, 16'h0040, 16'h0010, 0, 16'h0044, 0, 16'h0040);
        checkOutput("alloc_branch_pc", 32'(obsBpc), 32'h0054);
        checkOutput("alloc_mispredict", 32'(obsMis), 1);
        checkOutput("alloc_redirect", 32'(obsRed), 32'h0054);
        idleFetch(16'h0040);
        checkOutput("alloc_pred_taken", 32'(pred_taken), 1);
        checkOutput("alloc_pred_pc", 32'(pred_pc), 32'h0054);
        checkOutput("alloc_misp_count", mispredict_count, 1);

        // Hysteresis: taken, not taken, not taken
        applyStimulus(1, 1, 0, 1, 16'h0040, 16'h0010, 1, 16'h0054, 0, 16'h0040);
        checkOutput("hyst1_mispredict", 32'(obsMis), 0);
        idleFetch(16'h0040);
        checkOutput("hyst1_pred", 32'(pred_taken), 1);
        applyStimulus(1, 1, 0, 0, 16'h0040, 16'h0010, 1, 16'h0054, 0, 16'h0040);
        checkOutput("hyst2_mispredict", 32'(obsMis), 1);
        idleFetch(16'h0040);
        checkOutput("hyst2_pred", 32'(pred_taken), 1);
        applyStimulus(1, 1, 0, 0, 16'h0040, 16'h0010, 0, 16'h0044, 0, 16'h0040);
        checkOutput("hyst3_mispredict", 32'(obsMis), 0);
        idleFetch(16'h0040);
        checkOutput("hyst3_pred", 32'(pred_taken), 0);

        // Alias replacement by a jump at the same index
        applyStimulus(1, 0, 1, 0, 16'h0440, 16'h0020, 0, 16'h0444, 0, 16'h0000);
        idleFetch(16'h0040);
        checkOutput("alias_old_pred_pc", 32'(pred_pc), 32'h0044);
        idleFetch(16'h0440);
        checkOutput("alias_new_pred_taken", 32'(pred_taken), 1);
        checkOutput("alias_new_pred_pc", 32'(pred_pc), 32'h0464);

        // Wrap-around of both adders
        idleFetch(16'hFFFC);
        checkOutput("wrap_pred_pc", 32'(pred_pc), 32'h0000);
        applyStimulus(1, 1, 0, 0, 16'h0000, 16'hFFF8, 0, 16'h0004, 0, 16'hFFFC);
        checkOutput("wrap_branch_pc", 32'(obsBpc), 32'hFFFC);
        checkOutput("wrap_jump_pc", 32'(obsJpc), 32'hFFFC);

        // Clear wins over an allocating update
        applyStimulus(1, 1, 0, 1, 16'h0080, 16'h0100, 0, 16'h0084, 1, 16'h0000);
        idleFetch(16'h0080);
        checkOutput("clear_pred_taken", 32'(pred_taken), 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) randomStep();

        // Asynchronous reset in the middle of a cycle
        applyStimulus(1, 0, 1, 0, 16'h0040, 16'h0030, 0, 16'h0000, 0, 16'h0040);
        fetch_pc = 16'h0040;
        ex_valid = 1'b0;
        #1;
        arst = 1'b1;
        #1;
        checkOutput("arst_pred_taken", 32'(pred_taken), 0);
        checkOutput("arst_ctrl_count", ctrl_count, 0);
        modelReset();
        @(posedge clk);
        #1;
        arst = 1'b0;

        // Counter saturation on the 4-bit instance
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1, 1, 0, n % 2, 16'h0100 + 4 * (n % 4), 16'h0008,
                          0, 16'h0000, 0, 16'h0100);
        end
        checkOutput("sat_hold", 32'(s4CtrlCount), 32'hF);

        for (int n = 0; n < 100; n++) randomStep();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Watchdog so the bench always reaches its summary
    initial begin
        #200000;
        testsFailed++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
